// File: rtl/uart_port_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between two word requesters,
// with a transmit watchdog and a one-entry receive holding register.
module uart_port_arbiter #(
    parameter int unsigned TO_BITS   = 20,
    parameter int unsigned TO_CYCLES = 1000000,
    parameter int unsigned WIDTH     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic [31:0]      data0,
    output logic             ack0,
    input  logic             req1,
    input  logic [31:0]      data1,
    output logic             ack1,
    output logic [1:0]       grant,
    output logic             busy,
    output logic             uart_start,
    output logic [31:0]      uart_tx_data,
    input  logic             uart_txend,
    output logic             timeout_err,
    input  logic             clr_err,
    input  logic             rx_ready,
    input  logic [WIDTH-1:0] rx_data,
    output logic             rx_rd,
    output logic [WIDTH-1:0] rx_byte,
    output logic             rx_valid,
    input  logic             rx_ack
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_WAIT_END,
        S_DONE
    } state_t;

    localparam logic [TO_BITS-1:0] TO_LAST = TO_BITS'(TO_CYCLES - 1);

    state_t             state_q, state_d;
    logic [1:0]         grant_q, grant_d;
    logic               busy_q, busy_d;
    logic               uart_start_q, uart_start_d;
    logic               ack0_q, ack0_d;
    logic               ack1_q, ack1_d;
    logic               lp_q, lp_d;
    logic [31:0]        tx_data_q, tx_data_d;
    logic [TO_BITS-1:0] cnt_q, cnt_d;
    logic               timeout_err_q, timeout_err_d;
    logic               to_set;
    logic               sel;

    logic [WIDTH-1:0]   rx_byte_q, rx_byte_d;
    logic               rx_valid_q, rx_valid_d;
    logic               rd_lock_q, rd_lock_d;
    logic               rx_rd_c;

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        busy_d       = busy_q;
        uart_start_d = 1'b0;
        ack0_d       = 1'b0;
        ack1_d       = 1'b0;
        lp_d         = lp_q;
        tx_data_d    = tx_data_q;
        cnt_d        = cnt_q;
        to_set       = 1'b0;
        sel          = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (req0 || req1) begin
                    // On a tie the requester that did not own the port last wins.
                    sel          = (req0 && req1) ? ~lp_q : req1;
                    tx_data_d    = sel ? data1 : data0;
                    grant_d      = sel ? 2'b10 : 2'b01;
                    lp_d         = sel;
                    busy_d       = 1'b1;
                    uart_start_d = 1'b1;
                    state_d      = S_START;
                end
            end
            S_START: begin
                cnt_d   = '0;
                state_d = S_WAIT_END;
            end
            S_WAIT_END: begin
                cnt_d = cnt_q + 1'b1;
                if (uart_txend || (cnt_q == TO_LAST)) begin
                    to_set  = ~uart_txend;
                    ack0_d  = grant_q[0];
                    ack1_d  = grant_q[1];
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                grant_d = '0;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (to_set)
            timeout_err_d = 1'b1;
        else if (clr_err)
            timeout_err_d = 1'b0;
        else
            timeout_err_d = timeout_err_q;
    end

    always_comb begin
        rx_rd_c    = rx_ready && (!rx_valid_q || rx_ack) && !rd_lock_q;
        rd_lock_d  = rx_rd_c;
        rx_byte_d  = rx_byte_q;
        rx_valid_d = rx_valid_q;
        // A read in the same cycle as an ack keeps the register full with the new byte.
        if (rx_rd_c) begin
            rx_byte_d  = rx_data;
            rx_valid_d = 1'b1;
        end else if (rx_ack) begin
            rx_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            grant_q       <= '0;
            busy_q        <= 1'b0;
            uart_start_q  <= 1'b0;
            ack0_q        <= 1'b0;
            ack1_q        <= 1'b0;
            lp_q          <= 1'b1;
            tx_data_q     <= '0;
            cnt_q         <= '0;
            timeout_err_q <= 1'b0;
            rx_byte_q     <= '0;
            rx_valid_q    <= 1'b0;
            rd_lock_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            busy_q        <= busy_d;
            uart_start_q  <= uart_start_d;
            ack0_q        <= ack0_d;
            ack1_q        <= ack1_d;
            lp_q          <= lp_d;
            tx_data_q     <= tx_data_d;
            cnt_q         <= cnt_d;
            timeout_err_q <= timeout_err_d;
            rx_byte_q     <= rx_byte_d;
            rx_valid_q    <= rx_valid_d;
            rd_lock_q     <= rd_lock_d;
        end
    end

    assign ack0         = ack0_q;
    assign ack1         = ack1_q;
    assign grant        = grant_q;
    assign busy         = busy_q;
    assign uart_start   = uart_start_q;
    assign uart_tx_data = tx_data_q;
    assign timeout_err  = timeout_err_q;
    assign rx_rd        = rx_rd_c;
    assign rx_byte      = rx_byte_q;
    assign rx_valid     = rx_valid_q;

endmodule

// File: tb/tb_uart_port_arbiter.sv
// Directed bench for uart_port_arbiter: a long-watchdog instance for normal traffic
// and a 16-cycle-watchdog instance sharing the same inputs for timeout behaviour.
module tb_uart_port_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req0 = 1'b0, req1 = 1'b0;
    logic [31:0] data0 = '0, data1 = '0;
    logic        uart_txend = 1'b0, clr_err = 1'b0;
    logic        rx_ready = 1'b0, rx_ack = 1'b0;
    logic [7:0]  rx_data = '0;

    logic        ack0, ack1, busy, uart_start, timeout_err, rx_rd, rx_valid;
    logic [1:0]  grant;
    logic [31:0] uart_tx_data;
    logic [7:0]  rx_byte;

    logic        t_ack0, t_ack1, t_busy, t_uart_start, t_timeout_err, t_rx_rd, t_rx_valid;
    logic [1:0]  t_grant;
    logic [31:0] t_uart_tx_data;
    logic [7:0]  t_rx_byte;

    int n_run  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    uart_port_arbiter #(.TO_BITS(8), .TO_CYCLES(100), .WIDTH(8)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .data0(data0), .ack0(ack0),
        .req1(req1), .data1(data1), .ack1(ack1),
        .grant(grant), .busy(busy),
        .uart_start(uart_start), .uart_tx_data(uart_tx_data), .uart_txend(uart_txend),
        .timeout_err(timeout_err), .clr_err(clr_err),
        .rx_ready(rx_ready), .rx_data(rx_data), .rx_rd(rx_rd),
        .rx_byte(rx_byte), .rx_valid(rx_valid), .rx_ack(rx_ack)
    );

    uart_port_arbiter #(.TO_BITS(5), .TO_CYCLES(16), .WIDTH(8)) dut_to (
        .clk(clk), .rst(rst),
        .req0(req0), .data0(data0), .ack0(t_ack0),
        .req1(req1), .data1(data1), .ack1(t_ack1),
        .grant(t_grant), .busy(t_busy),
        .uart_start(t_uart_start), .uart_tx_data(t_uart_tx_data), .uart_txend(uart_txend),
        .timeout_err(t_timeout_err), .clr_err(clr_err),
        .rx_ready(rx_ready), .rx_data(rx_data), .rx_rd(t_rx_rd),
        .rx_byte(t_rx_byte), .rx_valid(t_rx_valid), .rx_ack(rx_ack)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        int         starts;
        int         acks;
        int         rds;
        logic [1:0] exp_g;

        // Reset state
        do_reset();
        check("rst_grant", grant, 2'b00);
        check("rst_busy", busy, 1'b0);
        check("rst_start", uart_start, 1'b0);
        check("rst_acks", {ack1, ack0}, 2'b00);
        check("rst_terr", timeout_err, 1'b0);
        check("rst_rxvalid", rx_valid, 1'b0);
        check("rst_txdata", uart_tx_data, 32'h0);
        check("rst_rxbyte", rx_byte, 8'h00);

        // 1: single transfer from requester 0, txend 50 cycles after start
        req0  = 1'b1;
        data0 = 32'hDEADBEEF;
        tick();
        check("t1_start", uart_start, 1'b1);
        check("t1_grant", grant, 2'b01);
        check("t1_txdata", uart_tx_data, 32'hDEADBEEF);
        check("t1_busy", busy, 1'b1);
        tick();
        starts = 0;
        acks   = 0;
        for (int i = 0; i < 49; i++) begin
            if (uart_start) starts++;
            if (ack0) acks++;
            tick();
        end
        check("t1_start_once", starts, 0);
        check("t1_no_early_ack", acks, 0);
        uart_txend = 1'b1;
        tick();
        uart_txend = 1'b0;
        check("t1_ack0", ack0, 1'b1);
        req0 = 1'b0;
        tick();
        check("t1_ack0_pulse", ack0, 1'b0);
        check("t1_busy_after", busy, 1'b0);
        check("t1_grant_after", grant, 2'b00);
        tick();
        check("t1_idle_start", uart_start, 1'b0);

        // 2: both requesting continuously -> alternating grants
        do_reset();
        req0  = 1'b1;
        req1  = 1'b1;
        data0 = 32'hA0A0A0A0;
        data1 = 32'hB1B1B1B1;
        for (int k = 0; k < 4; k++) begin
            exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
            tick();
            check("t2_grant", grant, exp_g);
            check("t2_txdata", uart_tx_data, exp_g[0] ? 32'hA0A0A0A0 : 32'hB1B1B1B1);
            tick();
            check("t2_no_ack_wait", {ack1, ack0}, 2'b00);
            uart_txend = 1'b1;
            tick();
            uart_txend = 1'b0;
            check("t2_acks", {ack1, ack0}, exp_g);
            if (exp_g[0]) req0 = 1'b0;
            else req1 = 1'b0;
            if (k == 3) begin
                req0 = 1'b0;
                req1 = 1'b0;
            end
            tick();
            check("t2_grant_idle", grant, 2'b00);
            if (k < 3) begin
                if (exp_g[0]) req0 = 1'b1;
                else req1 = 1'b1;
            end
        end

        // 3: watchdog on the 16-cycle instance
        do_reset();
        req1  = 1'b1;
        data1 = 32'h12345678;
        tick();
        check("t3_grant", t_grant, 2'b10);
        tick();
        acks = 0;
        for (int i = 0; i < 16; i++) begin
            if (t_timeout_err || t_ack1) acks++;
            tick();
        end
        check("t3_no_early_err", acks, 0);
        check("t3_terr_set", t_timeout_err, 1'b1);
        check("t3_ack1", t_ack1, 1'b1);
        req1 = 1'b0;
        tick();
        check("t3_idle_busy", t_busy, 1'b0);
        check("t3_idle_grant", t_grant, 2'b00);
        check("t3_terr_sticky", t_timeout_err, 1'b1);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        check("t3_terr_clr", t_timeout_err, 1'b0);
        req1 = 1'b1;
        tick();
        tick();
        for (int i = 0; i < 15; i++) tick();
        uart_txend = 1'b1;
        tick();
        uart_txend = 1'b0;
        check("t3b_ack1", t_ack1, 1'b1);
        check("t3b_no_err", t_timeout_err, 1'b0);
        req1 = 1'b0;
        tick();
        check("t3b_terr_idle", t_timeout_err, 1'b0);

        // 4: receive path with two queued bytes
        do_reset();
        rx_ready = 1'b1;
        rx_data  = 8'h41;
        rx_ack   = 1'b0;
        #1;
        check("t4_rd_first", rx_rd, 1'b1);
        tick();
        rx_data = 8'h42;
        #1;
        check("t4_valid", rx_valid, 1'b1);
        check("t4_byte41", rx_byte, 8'h41);
        rds = 0;
        for (int i = 0; i < 4; i++) begin
            if (rx_rd) rds++;
            tick();
        end
        check("t4_rd_held", rds, 0);
        check("t4_byte_kept", rx_byte, 8'h41);
        rx_ack = 1'b1;
        #1;
        check("t4_rd_on_ack", rx_rd, 1'b1);
        tick();
        rx_ack   = 1'b0;
        rx_ready = 1'b0;
        #1;
        check("t4_byte42", rx_byte, 8'h42);
        check("t4_valid2", rx_valid, 1'b1);
        rx_ack = 1'b1;
        tick();
        rx_ack = 1'b0;
        check("t4_drained", rx_valid, 1'b0);

        // 5: reset during WAIT_END with requester 1 granted
        do_reset();
        req1  = 1'b1;
        data1 = 32'hCAFEF00D;
        tick();
        tick();
        tick();
        check("t5_grant_before", grant, 2'b10);
        rst = 1'b1;
        tick();
        rst  = 1'b0;
        req1 = 1'b0;
        check("t5_grant", grant, 2'b00);
        check("t5_busy", busy, 1'b0);
        check("t5_ack1", ack1, 1'b0);
        check("t5_txdata", uart_tx_data, 32'h0);
        tick();
        check("t5_no_late_ack", ack1, 1'b0);
        req0  = 1'b1;
        data0 = 32'h0BADC0DE;
        tick();
        check("t5_regrant", grant, 2'b01);
        check("t5_retx", uart_tx_data, 32'h0BADC0DE);
        tick();
        uart_txend = 1'b1;
        tick();
        uart_txend = 1'b0;
        check("t5_ack0", ack0, 1'b1);
        req0 = 1'b0;
        tick();

        // 6: stray txend in IDLE, data change after grant
        do_reset();
        uart_txend = 1'b1;
        tick();
        uart_txend = 1'b0;
        check("t6_no_stray_ack", {ack1, ack0}, 2'b00);
        check("t6_idle_busy", busy, 1'b0);
        tick();
        check("t6_no_stray_ack2", {ack1, ack0}, 2'b00);
        req0  = 1'b1;
        data0 = 32'h11112222;
        tick();
        data0 = 32'h33334444;
        tick();
        check("t6_txdata_held", uart_tx_data, 32'h11112222);
        uart_txend = 1'b1;
        tick();
        uart_txend = 1'b0;
        check("t6_ack0", ack0, 1'b1);
        check("t6_txdata_done", uart_tx_data, 32'h11112222);
        req0 = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
